// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: IF/ID front-end sequencer for the R2000 pipeline.
// Handles load-use, HI/LO interlock, taken branch (one delay slot), exceptions
// and instruction-memory wait states. It also owns the mult/div busy counter
// and a saturating stall-cycle counter.
// Ports:
//   clk, rst_n            clock and async active-low reset
//   i_id_*                register usage of the instruction in ID
//   i_ex_mem_read/i_ex_rt load in EX and its destination register
//   i_md_start_mult/div   mult/div issue from EX
//   i_br_taken, i_except  redirect requests
//   i_imem_ready          fetch returns a valid word this cycle
//   o_pc_en/o_pc_sel      PC load enable / source (00 +4, 01 branch, 10 vector)
//   o_ifid_en/o_ifid_flush, o_idex_flush   pipeline register controls
//   o_md_busy             HI/LO result pending
//   o_stall_cnt           saturating count of stalled RUN cycles
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 12,
  parameter int unsigned DIV_CYCLES  = 35,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic             i_id_reads_hilo,
  input  logic             i_id_md_op,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_rt,
  input  logic             i_md_start_mult,
  input  logic             i_md_start_div,
  input  logic             i_br_taken,
  input  logic             i_except,
  input  logic             i_imem_ready,
  output logic             o_pc_en,
  output logic [1:0]       o_pc_sel,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_md_busy,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int unsigned MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned MD_W   = $clog2(MD_MAX);

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_EXC = 2'b10;

  typedef enum logic [1:0] {ST_RESET = 2'd0, ST_RUN = 2'd1, ST_EXC = 2'd2} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [MD_W-1:0]  r_md_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_md_busy;
  logic       w_load_use;
  logic       w_hilo_use;
  logic       w_pc_en;
  logic [1:0] w_pc_sel;
  logic       w_ifid_en;
  logic       w_ifid_flush;
  logic       w_idex_flush;

  assign w_md_busy  = (r_md_cnt != '0);
  // Register 0 never carries a loaded value, so it cannot create a hazard.
  assign w_load_use = i_ex_mem_read && (i_ex_rt != 5'd0) &&
                      ((i_id_uses_rs && (i_id_rs == i_ex_rt)) ||
                       (i_id_uses_rt && (i_id_rt == i_ex_rt)));
  assign w_hilo_use = w_md_busy && (i_id_reads_hilo || i_id_md_op);

  // Next-state and control decode; RESET values are the defaults.
  always_comb begin
    w_next       = r_state;
    w_pc_en      = 1'b0;
    w_pc_sel     = PC_SEQ;
    w_ifid_en    = 1'b0;
    w_ifid_flush = 1'b1;
    w_idex_flush = 1'b1;
    case (r_state)
      ST_RESET: w_next = ST_RUN;
      ST_RUN: begin
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        if (i_except) begin
          w_pc_sel     = PC_EXC;
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
          w_next       = ST_EXC;
        end else if (i_br_taken) begin
          // Delay slot in ID proceeds; the fetch behind it is squashed.
          w_pc_sel     = PC_BR;
          w_ifid_flush = 1'b1;
        end else if (w_load_use || w_hilo_use) begin
          w_pc_en      = 1'b0;
          w_ifid_en    = 1'b0;
          w_idex_flush = 1'b1;
        end else if (!i_imem_ready) begin
          // Fetch bubble: IF/ID takes a NOP while ID/EX drains.
          w_pc_en      = 1'b0;
          w_ifid_flush = 1'b1;
        end
      end
      ST_EXC: begin
        w_pc_en   = 1'b1;
        w_ifid_en = 1'b1;
        w_next    = ST_RUN;
        if (i_except) begin
          w_pc_sel = PC_EXC;
          w_next   = ST_EXC;
        end
      end
      default: w_next = ST_RESET;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RESET;
    else        r_state <= w_next;
  end

  // HI/LO busy counter; an exception abandons the pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt <= '0;
    end else if (r_state == ST_RESET || i_except) begin
      r_md_cnt <= '0;
    end else if (i_md_start_div) begin
      r_md_cnt <= MD_W'(DIV_CYCLES - 1);
    end else if (i_md_start_mult) begin
      r_md_cnt <= MD_W'(MULT_CYCLES - 1);
    end else if (w_md_busy) begin
      r_md_cnt <= r_md_cnt - MD_W'(1);
    end
  end

  // Saturating count of RUN cycles in which the PC is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_state == ST_RUN && !w_pc_en && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_pc_en      = w_pc_en;
  assign o_pc_sel     = w_pc_sel;
  assign o_ifid_en    = w_ifid_en;
  assign o_ifid_flush = w_ifid_flush;
  assign o_idex_flush = w_idex_flush;
  assign o_md_busy    = w_md_busy;
  assign o_stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench for pipe_hazard_ctrl (CNT_W = 4).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  // ctl = {pc_en, ifid_en, ifid_flush, idex_flush, pc_sel}
  localparam logic [5:0] C_RESET = 6'b001100;
  localparam logic [5:0] C_RUN   = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b000100;
  localparam logic [5:0] C_IWAIT = 6'b011000;
  localparam logic [5:0] C_BR    = 6'b111001;
  localparam logic [5:0] C_EXCRQ = 6'b111110;
  localparam logic [5:0] C_EXC   = 6'b111100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rs = 0, id_uses_rt = 0, id_reads_hilo = 0, id_md_op = 0;
  logic ex_mem_read = 0, md_start_mult = 0, md_start_div = 0;
  logic br_taken = 0, except_r = 0, imem_ready = 1;
  logic pc_en, ifid_en, ifid_flush, idex_flush, md_busy;
  logic [1:0] pc_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [5:0] ctl;

  int n_cmp = 0;
  int n_err = 0;

  assign ctl = {pc_en, ifid_en, ifid_flush, idex_flush, pc_sel};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_CYCLES(12), .DIV_CYCLES(35), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rs(id_uses_rs), .i_id_uses_rt(id_uses_rt),
    .i_id_reads_hilo(id_reads_hilo), .i_id_md_op(id_md_op),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt),
    .i_md_start_mult(md_start_mult), .i_md_start_div(md_start_div),
    .i_br_taken(br_taken), .i_except(except_r), .i_imem_ready(imem_ready),
    .o_pc_en(pc_en), .o_pc_sel(pc_sel), .o_ifid_en(ifid_en),
    .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush),
    .o_md_busy(md_busy), .o_stall_cnt(stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_reads_hilo = 0; id_md_op = 0;
    ex_mem_read = 0; md_start_mult = 0; md_start_div = 0;
    br_taken = 0; except_r = 0; imem_ready = 1;
  endtask

  // Pulse reset for one edge and leave the DUT one edge into RUN.
  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) step();
    #1;
    n_cmp++; if (ctl !== C_RESET) begin n_err++; $display("FAIL reset_ctl got %b want %b", ctl, C_RESET); end
    n_cmp++; if ({md_busy, stall_cnt} !== 5'b0) begin n_err++; $display("FAIL reset_regs got %b want 0", {md_busy, stall_cnt}); end
    rst_n = 1;
    #1;
    n_cmp++; if (ctl !== C_RESET) begin n_err++; $display("FAIL reset_hold got %b want %b", ctl, C_RESET); end
    step();
    #1;
    n_cmp++; if (ctl !== C_RUN) begin n_err++; $display("FAIL reset_exit got %b want %b", ctl, C_RUN); end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_mem_read = 1; ex_rt = 5'd5; id_uses_rs = 1; id_rs = 5'd5;
    #1;
    n_cmp++; if (ctl !== C_STALL) begin n_err++; $display("FAIL lu_rs got %b want %b", ctl, C_STALL); end
    step();
    ex_mem_read = 0;
    #1;
    n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
    n_cmp++; if (ctl !== C_RUN) begin n_err++; $display("FAIL lu_release got %b want %b", ctl, C_RUN); end
    ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    n_cmp++; if (ctl !== C_RUN) begin n_err++; $display("FAIL lu_r0 got %b want %b", ctl, C_RUN); end
    ex_rt = 5'd7; id_uses_rs = 0; id_rs = 5'd7; id_uses_rt = 1; id_rt = 5'd7;
    #1;
    n_cmp++; if (ctl !== C_STALL) begin n_err++; $display("FAIL lu_rt got %b want %b", ctl, C_STALL); end
    id_uses_rt = 0;
    #1;
    n_cmp++; if (ctl !== C_RUN) begin n_err++; $display("FAIL lu_unused got %b want %b", ctl, C_RUN); end
    step();
    ex_mem_read = 0;
    #1;
    n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL lu_cnt2 got %0d want 1", stall_cnt); end
  endtask

  task automatic test_hilo();
    apply_reset();
    md_start_mult = 1; id_reads_hilo = 1;
    #1;
    n_cmp++; if ({md_busy, ctl} !== {1'b0, C_RUN}) begin n_err++; $display("FAIL hilo_issue got %b want %b", {md_busy, ctl}, {1'b0, C_RUN}); end
    step();
    md_start_mult = 0;
    for (int i = 0; i < 11; i++) begin
      #1;
      n_cmp++; if ({md_busy, ctl} !== {1'b1, C_STALL}) begin n_err++; $display("FAIL hilo_busy%0d got %b want %b", i, {md_busy, ctl}, {1'b1, C_STALL}); end
      step();
    end
    #1;
    n_cmp++; if ({md_busy, ctl} !== {1'b0, C_RUN}) begin n_err++; $display("FAIL hilo_release got %b want %b", {md_busy, ctl}, {1'b0, C_RUN}); end
    n_cmp++; if (stall_cnt !== 4'd11) begin n_err++; $display("FAIL hilo_cnt got %0d want 11", stall_cnt); end
    id_reads_hilo = 0;
  endtask

  task automatic test_branch();
    apply_reset();
    br_taken = 1; ex_mem_read = 1; ex_rt = 5'd9; id_uses_rs = 1; id_rs = 5'd9; imem_ready = 0;
    #1;
    n_cmp++; if (ctl !== C_BR) begin n_err++; $display("FAIL br_over_lu got %b want %b", ctl, C_BR); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL br_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_exception();
    apply_reset();
    md_start_div = 1;
    step();
    md_start_div = 0; imem_ready = 0;
    #1;
    n_cmp++; if ({md_busy, ctl} !== {1'b1, C_IWAIT}) begin n_err++; $display("FAIL exc_iwait got %b want %b", {md_busy, ctl}, {1'b1, C_IWAIT}); end
    step();
    except_r = 1;
    #1;
    n_cmp++; if (ctl !== C_EXCRQ) begin n_err++; $display("FAIL exc_req got %b want %b", ctl, C_EXCRQ); end
    step();
    except_r = 0;
    #1;
    n_cmp++; if ({md_busy, ctl} !== {1'b0, C_EXC}) begin n_err++; $display("FAIL exc_state got %b want %b", {md_busy, ctl}, {1'b0, C_EXC}); end
    step();
    imem_ready = 1;
    #1;
    n_cmp++; if (ctl !== C_RUN) begin n_err++; $display("FAIL exc_return got %b want %b", ctl, C_RUN); end
    n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL exc_cnt got %0d want 1", stall_cnt); end
    except_r = 1;
    step();
    #1;
    n_cmp++; if (ctl !== C_EXCRQ) begin n_err++; $display("FAIL exc_reenter got %b want %b", ctl, C_EXCRQ); end
    step();
    except_r = 0;
    #1;
    n_cmp++; if (ctl !== C_EXC) begin n_err++; $display("FAIL exc_again got %b want %b", ctl, C_EXC); end
    step();
    #1;
    n_cmp++; if (ctl !== C_RUN) begin n_err++; $display("FAIL exc_return2 got %b want %b", ctl, C_RUN); end
  endtask

  task automatic test_md_reload();
    int n;
    apply_reset();
    md_start_mult = 1;
    step();
    md_start_mult = 0;
    step(); step();
    md_start_mult = 1; md_start_div = 1;
    step();
    md_start_mult = 0; md_start_div = 0;
    n = 0;
    while (md_busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    n_cmp++; if (n !== 34) begin n_err++; $display("FAIL md_reload got %0d want 34", n); end
    md_start_mult = 1;
    step();
    md_start_mult = 0;
    rst_n = 0;
    #1;
    n_cmp++; if ({md_busy, ctl} !== {1'b0, C_RESET}) begin n_err++; $display("FAIL md_async_rst got %b want %b", {md_busy, ctl}, {1'b0, C_RESET}); end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_saturation();
    apply_reset();
    imem_ready = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 14) begin
        n_cmp++; if (stall_cnt !== 4'd14) begin n_err++; $display("FAIL sat_mid got %0d want 14", stall_cnt); end
      end
      step();
    end
    n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_end got %0d want 15", stall_cnt); end
    imem_ready = 1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_hilo();
    test_branch();
    test_exception();
    test_md_reload();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing unit for the IF/ID front end of the MIPS R2000 pipeline.
- Generates the PC enable, PC mux select, IF/ID enable and flush, and ID/EX bubble.
- Handles load-use hazards, HI/LO multiply/divide interlock, taken branches (one delay slot), exceptions and instruction-memory wait states.
- Owns the multi-cycle mult/div busy counter and a stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 12, total cycles HI/LO are busy after a MULT/MULTU issues (must be ≥ 2).
- DIV_CYCLES, 35, total cycles HI/LO are busy after a DIV/DIVU issues (must be ≥ 2).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
- id_reads_hilo  in  1  ID instruction is MFHI/MFLO.
- id_md_op  in  1  ID instruction is MULT/MULTU/DIV/DIVU.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rt  in  5  destination register of the EX load.
- md_start_mult, md_start_div  in  1 each  EX issues a mult / div this cycle.
- br_taken  in  1  branch/jump in EX is taken.
- except  in  1  exception request.
- imem_ready  in  1  instruction memory returns a valid word this cycle.
- pc_en  out  1  PC register load enable.
- pc_sel  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = exception vector.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID loads NOP.
- idex_flush  out  1  ID/EX loads NOP (bubble).
- md_busy  out  1  HI/LO result pending.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- FSM states: RESET, RUN, EXC. Control outputs are combinational from state and inputs; state, md counter and stall_cnt are registered.
- Async reset:
  - state = RESET, md counter = 0, stall_cnt = 0.
  - Outputs while in RESET: pc_en = 0, ifid_en = 0, ifid_flush = 1, idex_flush = 1, pc_sel = 00, md_busy = 0.
  - RESET → RUN on the first clk edge after rst_n deasserts. Reset asserted mid-operation returns to RESET immediately and discards any pending mult/div.
- RUN priority, highest first (defaults: pc_en = 1, ifid_en = 1, flushes = 0, pc_sel = 00):
  1. except: pc_sel = 10, pc_en = 1, ifid_flush = 1, idex_flush = 1; md counter cleared; next state EXC.
  2. br_taken: pc_sel = 01, pc_en = 1, ifid_flush = 1, idex_flush = 0. The delay-slot instruction in ID proceeds. Overrides imem wait; any in-flight fetch is discarded.
  3. Load-use: ex_mem_read && ex_rt != 0 && ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt)) → pc_en = 0, ifid_en = 0, idex_flush = 1. Lasts exactly one cycle per load.
  4. HI/LO interlock: md_busy && (id_reads_hilo || id_md_op) → same outputs as load-use; held until md_busy falls.
  5. imem_ready = 0: pc_en = 0, ifid_flush = 1, ifid_en = 1, idex_flush = 0. ID/EX drains normally.
- EXC state (one cycle): pc_en = 1, pc_sel = 00, ifid_flush = 1, idex_flush = 1; then → RUN. An except arriving during EXC re-enters EXC with pc_sel = 10.
- md counter:
  - Loads MULT_CYCLES-1 on md_start_mult, DIV_CYCLES-1 on md_start_div; if both are asserted, div wins.
  - Decrements to 0 otherwise; md_busy = (counter != 0).
  - A start while busy reloads the counter.
- stall_cnt increments in any cycle where pc_en = 0 while in RUN; saturates at all-ones; not incremented in RESET or EXC.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles, release → RESET outputs during reset (pc_en = 0, both flushes = 1); pc_en = 1, pc_sel = 00 one edge after release.
- Load-use: ex_mem_read = 1, ex_rt = 5, id_uses_rs = 1, id_rs = 5 → one cycle with pc_en = 0, ifid_en = 0, idex_flush = 1; stall_cnt increments by 1. Same stimulus with ex_rt = 0 → no stall.
- HI/LO interlock: md_start_mult pulse, then id_reads_hilo = 1 → md_busy high for exactly 11 cycles after the pulse, stall held throughout, release on the cycle md_busy = 0; stall_cnt = 11.
- Branch vs. load-use: br_taken = 1 together with a load-use match → pc_sel = 01, ifid_flush = 1, idex_flush = 0, pc_en = 1.
- Exception during imem wait and div: imem_ready = 0 with div busy, assert except → pc_sel = 10, both flushes = 1, md_busy = 0 the next cycle; EXC lasts one cycle, then RUN.
- Saturation: CNT_W = 4, hold imem_ready = 0 for 20 cycles → stall_cnt stops at 15.
